// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
//   Shared types and constants for the run-time clock divider controller.
//   - state_t : controller FSM states
//   - MIN_DIV : smallest divide ratio the divider can produce
// ---------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // stopped, clk_out low, counter cleared
        RUN   = 3'd1,   // free-running divide-by-N
        STOP  = 3'd2,   // finishing the current period before going idle
        DRAIN = 3'd3,   // finishing the current period before a ratio change
        GATE  = 3'd4,   // clk_out held low between old and new ratio
        LOAD  = 3'd5    // new ratio copied into the divider
    } state_t;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// ---------------------------------------------------------------------------
// clk_div_core
//   Period counter of the divider. Counts 0..div-1 and wraps, and produces
//   the next-cycle duty decision so the controller can register clk_out in
//   the same edge that updates the counter.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous active-low reset (cnt -> 0)
//   div          in   DIV_W  current divide ratio (>= 2 whenever adv is set)
//   adv          in   1      advance the counter this cycle
//   clr          in   1      force the counter to 0 this cycle (wins over adv)
//   clk_out_nxt  out  1      value clk_out should take at the coming edge
//   term         out  1      counter is on the last cycle of the period
// ---------------------------------------------------------------------------
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             adv,
    input  logic             clr,
    output logic             clk_out_nxt,
    output logic             term
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;

    // ceil(n/2), one bit wider so n = 2^DIV_W-1 does not overflow.
    function automatic logic [DIV_W:0] half_up(input logic [DIV_W-1:0] n);
        return ({1'b0, n} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    endfunction

    assign term = (cnt == div - ONE);

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (adv) begin
            cnt_nxt = term ? '0 : cnt + ONE;
        end
    end

    // High for the first ceil(N/2) counts: 50% for even N, one extra
    // high cycle for odd N.
    assign clk_out_nxt = ({1'b0, cnt_nxt} < half_up(div));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//   Run-time controller for the divide-by-N clock generator. Ratio changes
//   arrive on a valid/ready port and are applied glitch-free: the current
//   period is drained, clk_out is gated low for GATE_CYCLES cycles, the new
//   ratio is loaded and the divider restarts at the top of a period.
//
// Parameters
//   DIV_W        width of the divide ratio
//   DEFAULT_DIV  ratio loaded at reset (>= 2)
//   GATE_CYCLES  cycles clk_out is held low between old and new ratio (>= 1)
//
// Ports
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous active-low reset
//   en           in   1      run the divider; 0 stops at the period boundary
//   cfg_valid    in   1      new ratio request
//   cfg_div      in   DIV_W  requested ratio; legal range 2..2^DIV_W-1
//   cfg_ready    out  1      request accepted on cfg_valid & cfg_ready
//   cfg_err      out  1      one-cycle pulse after an illegal ratio was taken
//   clk_out      out  1      registered divided clock
//   tick         out  1      last cycle of each RUN period
//   busy         out  1      a ratio change is in progress
// ---------------------------------------------------------------------------
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4,
    parameter int unsigned GATE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    localparam int unsigned      GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    state_t            state;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  pend_q;
    logic [GATE_W-1:0] gate_cnt;

    logic cfg_fire;
    logic cfg_legal;
    logic adv;
    logic clr;
    logic clk_out_nxt;
    logic term;

    // Handshake is decoded straight from the state register so it is
    // already valid (ready=1) while reset is held.
    assign cfg_ready = (state == IDLE) || (state == RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_legal = (cfg_div >= DIV_W'(MIN_DIV));

    assign busy = (state == DRAIN) || (state == GATE) || (state == LOAD);
    assign tick = (state == RUN) && term;

    // The counter runs only while a period is being produced. IDLE and LOAD
    // pin it at 0 so every restart begins with a full high phase; GATE just
    // holds the 0 left behind by the drained period's wrap.
    assign adv = (state == RUN) || (state == STOP) || (state == DRAIN);
    assign clr = (state == IDLE) || (state == LOAD);

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .div         (div_q),
        .adv         (adv),
        .clr         (clr),
        .clk_out_nxt (clk_out_nxt),
        .term        (term)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            div_q    <= DIV_W'(DEFAULT_DIV);
            pend_q   <= '0;
            gate_cnt <= '0;
            clk_out  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            // Illegal ratios still complete the handshake; they only flag.
            cfg_err <= cfg_fire && !cfg_legal;

            case (state)
                IDLE: begin
                    // No output is running, so a new ratio can be taken
                    // directly without the drain/gate sequence.
                    if (cfg_fire && cfg_legal) begin
                        div_q <= cfg_div;
                    end
                    if (en) begin
                        state   <= RUN;
                        clk_out <= clk_out_nxt;
                    end else begin
                        clk_out <= 1'b0;
                    end
                end

                RUN: begin
                    clk_out <= clk_out_nxt;
                    if (cfg_fire && cfg_legal) begin
                        pend_q <= cfg_div;
                        state  <= DRAIN;
                    end else if (!en) begin
                        state <= STOP;
                    end
                end

                STOP: begin
                    // Ending on the terminal count means the last phase
                    // emitted was a full low phase: no runt pulse.
                    if (term) begin
                        state   <= IDLE;
                        clk_out <= 1'b0;
                    end else begin
                        clk_out <= clk_out_nxt;
                    end
                end

                DRAIN: begin
                    if (term) begin
                        state    <= GATE;
                        gate_cnt <= '0;
                        clk_out  <= 1'b0;
                    end else begin
                        clk_out <= clk_out_nxt;
                    end
                end

                GATE: begin
                    clk_out <= 1'b0;
                    if (gate_cnt == GATE_LAST) begin
                        state <= LOAD;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                    end
                end

                LOAD: begin
                    // en is only looked at here during a change, so a stop
                    // requested mid-change takes effect once the new ratio
                    // is in place.
                    div_q <= pend_q;
                    if (en) begin
                        state   <= RUN;
                        clk_out <= clk_out_nxt;
                    end else begin
                        state   <= IDLE;
                        clk_out <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    clk_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
//   Directed bench for clk_div_ctrl with hand-derived per-cycle waveforms.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       tick;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    clk_div_ctrl #(
        .DIV_W       (8),
        .DEFAULT_DIV (4),
        .GATE_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles; bit n-1-i of each vector is the value expected
    // just after edge i.
    task automatic run_wave(input string tag, input int n,
                            input logic [31:0] e_clk, input logic [31:0] e_tick,
                            input logic [31:0] e_busy, input logic [31:0] e_rdy,
                            input logic [31:0] e_err);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s[%0d].clk_out", tag, i), {31'd0, clk_out},   {31'd0, e_clk[n-1-i]});
            chk($sformatf("%s[%0d].tick", tag, i),    {31'd0, tick},      {31'd0, e_tick[n-1-i]});
            chk($sformatf("%s[%0d].busy", tag, i),    {31'd0, busy},      {31'd0, e_busy[n-1-i]});
            chk($sformatf("%s[%0d].ready", tag, i),   {31'd0, cfg_ready}, {31'd0, e_rdy[n-1-i]});
            chk($sformatf("%s[%0d].err", tag, i),     {31'd0, cfg_err},   {31'd0, e_err[n-1-i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;

        // Reset state
        step();
        step();
        chk("rst.clk_out", {31'd0, clk_out},   32'd0);
        chk("rst.tick",    {31'd0, tick},      32'd0);
        chk("rst.busy",    {31'd0, busy},      32'd0);
        chk("rst.err",     {31'd0, cfg_err},   32'd0);
        chk("rst.ready",   {31'd0, cfg_ready}, 32'd1);
        reset_n = 1'b1;
        run_wave("idle", 1, 0, 0, 0, 1, 0);

        // Default N=4, first high one cycle after en
        en = 1'b1;
        run_wave("t1", 8, 8'b11001100, 8'b00010001, 0, 8'hFF, 0);

        // Illegal ratio 1 in RUN: err pulse, waveform undisturbed
        cfg_div   = 8'd1;
        cfg_valid = 1'b1;
        run_wave("t4a", 1, 1, 0, 0, 1, 1);
        cfg_valid = 1'b0;
        run_wave("t4b", 7, 7'b1001100, 7'b0010001, 0, 7'h7F, 0);

        // N 4 -> 6 requested at cnt=1
        run_wave("t3a", 2, 2'b11, 0, 0, 2'b11, 0);
        cfg_div   = 8'd6;
        cfg_valid = 1'b1;
        run_wave("t3b", 1, 0, 0, 1, 0, 0);
        cfg_valid = 1'b0;
        run_wave("t3c", 12, 12'b000011100011, 12'b000000000100,
                 12'b111100000000, 12'b000011111111, 0);

        // en=0 at cnt=0 with N=6: 3 high + 3 low, then IDLE
        run_wave("t5a", 5, 5'b10001, 5'b00010, 0, 5'h1F, 0);
        en = 1'b0;
        run_wave("t5b", 7, 7'b1100000, 0, 0, 7'b0000011, 0);

        // N=5 loaded in IDLE, no gating
        cfg_div   = 8'd5;
        cfg_valid = 1'b1;
        run_wave("t2a", 1, 0, 0, 0, 1, 0);
        cfg_valid = 1'b0;
        en        = 1'b1;
        run_wave("t2b", 10, 10'b1110011100, 10'b0000100001, 0, 10'h3FF, 0);

        // N 5 -> 3, second request (7) held through the change
        run_wave("t6a", 1, 1, 0, 0, 1, 0);
        cfg_div   = 8'd3;
        cfg_valid = 1'b1;
        run_wave("t6b", 1, 1, 0, 1, 0, 0);
        cfg_div = 8'd7;
        run_wave("t6c", 8, 8'b10000011, 0, 8'b11111101, 8'b00000010, 0);
        cfg_valid = 1'b0;
        run_wave("t6d", 2, 0, 0, 2'b11, 0, 0);

        // Reset asserted mid-GATE: immediate return, pending 7 dropped
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6r.clk_out", {31'd0, clk_out},   32'd0);
        chk("t6r.busy",    {31'd0, busy},      32'd0);
        chk("t6r.ready",   {31'd0, cfg_ready}, 32'd1);
        chk("t6r.tick",    {31'd0, tick},      32'd0);
        step();
        step();
        reset_n = 1'b1;
        run_wave("t6e", 8, 8'b11001100, 8'b00010001, 0, 8'hFF, 0);

        // N 4 -> 2 with en dropped during DRAIN: IDLE after LOAD
        run_wave("t7a", 1, 1, 0, 0, 1, 0);
        cfg_div   = 8'd2;
        cfg_valid = 1'b1;
        run_wave("t7b", 1, 1, 0, 1, 0, 0);
        cfg_valid = 1'b0;
        en        = 1'b0;
        run_wave("t7c", 7, 0, 0, 7'b1111100, 7'b0000011, 0);
        en = 1'b1;
        run_wave("t7d", 4, 4'b1010, 4'b0101, 0, 4'hF, 0);

        // Stop with N=2, then illegal ratio 0 in IDLE leaves N=2
        run_wave("t8a", 1, 1, 0, 0, 1, 0);
        en = 1'b0;
        run_wave("t8b", 2, 0, 0, 0, 2'b01, 0);
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        run_wave("t8c", 1, 0, 0, 0, 1, 1);
        cfg_valid = 1'b0;
        en        = 1'b1;
        run_wave("t8d", 4, 4'b1010, 4'b0101, 0, 4'hF, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
